if_prefetch_buf: RTL and testbench
==================================

IF_PREFETCH_BUF -- requirements
Module: if_prefetch_buf

Interface
REQ-001 Parameter DEPTH, 4, FIFO entries (power of two, 2..16), SHALL be honoured.
REQ-002 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset, SHALL be honoured.
REQ-003 clk  in  1  sole clock, all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low, SHALL clear all state when 0.
REQ-005 flush  in  1  branch/exception redirect, SHALL discard buffered and in-flight fetches.
REQ-006 new_pc  in  32  redirect target, SHALL be sampled when flush=1.
REQ-007 stall  in  1  downstream (IF/ID) hold, SHALL block pops when 1.
REQ-008 rom_ce  out  1  instruction ROM read enable.
REQ-009 rom_addr  out  32  instruction ROM byte address.
REQ-010 rom_data  in  32  ROM read data, valid exactly one cycle after rom_ce=1.
REQ-011 if_pc  out  32  PC of head instruction.
REQ-012 if_inst  out  32  head instruction word.
REQ-013 if_valid  out  1  head entry valid.

Function
REQ-014 Registered fetch_pc SHALL drive rom_addr; rom_ce=1 SHALL be asserted in any cycle where (occupancy + in-flight) < DEPTH after this cycle's pop, and flush=0.
REQ-015 Each issued read SHALL advance fetch_pc by 4 (wraps modulo 2^32) and mark one in-flight slot carrying its PC.
REQ-016 Next cycle, rom_data SHALL be written into FIFO with its PC tag and the in-flight mark cleared.
REQ-017 Non-empty FIFO: if_valid=1, if_pc/if_inst = head entry; empty: if_valid=0, if_pc/if_inst = 0.
REQ-018 Pop SHALL occur when if_valid=1 and stall=0; simultaneous pop and push on a full-minus-one or full FIFO SHALL be accepted without loss.
REQ-019 Occupancy SHALL never exceed DEPTH; no read issued that could overflow it.
REQ-020 flush=1 SHALL, at the edge: empty FIFO, cancel in-flight (its rom_data ignored next cycle), set fetch_pc=new_pc; rom_ce SHALL be 0 in the flush cycle and reissue from new_pc next cycle.
REQ-021 flush and stall both 1: flush SHALL win; no pop counted.
REQ-022 Consecutive flushes SHALL each redirect; only the last new_pc is fetched.
REQ-023 new_pc[1:0] ignored; rom_addr[1:0] SHALL always be 00.

Reset
REQ-024 While rst=0: rom_ce=0, rom_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0, FIFO empty, no in-flight.
REQ-025 First rising edge after rst rises SHALL see rom_ce=1, rom_addr=RESET_PC.
REQ-026 rst asserted mid-operation SHALL drop all entries and in-flight data immediately, without waiting for clk.

Configuration
REQ-027 Macro PREFETCH_BYPASS_EN defined: when FIFO empty and returning rom_data not cancelled, it SHALL be presented on if_inst/if_pc with if_valid=1 combinationally that cycle, and SHALL not be written if popped (stall=0); fetch-to-output latency 1 cycle.
REQ-028 Macro undefined: all data SHALL pass through FIFO; fetch-to-output latency 2 cycles; no combinational path rom_data -> if_*.

Verification
REQ-029 Reset release, ROM[i]=i, stall=0 -> rom_addr 0,4,8,...; if_pc 0,4,8 with if_inst 0,1,2 back-to-back, first if_valid 2 cycles after first rom_ce (1 with PREFETCH_BYPASS_EN).
REQ-030 stall=1 held 10 cycles, DEPTH=4 -> exactly 4 entries buffered, rom_ce=0 after; release -> pcs continue gap-free, none duplicated.
REQ-031 flush=1, new_pc=32'h0000_0100 while 3 entries + 1 in-flight -> next cycle if_valid=0, rom_addr=0x100; next delivered if_pc=0x100.
REQ-032 flush=1 with stall=1 same cycle -> redirect taken, old head discarded.
REQ-033 rst pulsed low mid-stream between clk edges -> if_valid=0 immediately; restart at RESET_PC.
REQ-034 fetch_pc=32'hFFFF_FFFC via flush -> following fetch rom_addr=32'h0000_0000.

Source files
------------

// File: rtl/if_prefetch_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : if_prefetch_buf
//  Purpose  : Instruction-fetch prefetch buffer. Issues sequential ROM reads
//             from a registered fetch PC, parks returning words with their PC
//             tags in a DEPTH-entry FIFO and presents the head to IF/ID.
//             flush redirects the fetch stream and drops everything in flight.
//  Options  : PREFETCH_BYPASS_EN - when defined, a returning ROM word is
//             forwarded straight to if_* while the FIFO is empty.
//  Revision : 1.0 - initial release
// ============================================================================
module if_prefetch_buf #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        stall,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  localparam int            c_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            c_CW    = c_AW + 1;
  localparam logic [c_CW:0] c_DEPTH = (c_CW + 1)'(DEPTH);

  // PCs are word aligned, so only bits [31:2] are stored anywhere.
  logic [29:0]     r_fetch_pc;
  logic            r_inflight;
  logic [29:0]     r_inflight_pc;
  logic [31:0]     r_mem_inst [DEPTH];
  logic [29:0]     r_mem_pc   [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_CW-1:0] r_count;

  logic            w_empty;
  logic            w_bypass;
  logic            w_pop;
  logic            w_pop_fifo;
  logic            w_push;
  logic [c_CW:0]   w_level;
  logic            w_issue;
  logic            w_unused_bits;

  assign w_unused_bits = &{1'b0, new_pc[1:0]};
  assign w_empty       = (r_count == '0);

`ifdef PREFETCH_BYPASS_EN
  assign w_bypass = w_empty && r_inflight;
`else
  assign w_bypass = 1'b0;
`endif

  // Head presentation: FIFO head, the forwarded ROM word, or zeros when empty.
  always_comb begin
    if_valid = 1'b0;
    if_pc    = 32'h0;
    if_inst  = 32'h0;
    if (!w_empty) begin
      if_valid = 1'b1;
      if_pc    = {r_mem_pc[r_rd_ptr], 2'b00};
      if_inst  = r_mem_inst[r_rd_ptr];
    end
`ifdef PREFETCH_BYPASS_EN
    else if (w_bypass) begin
      if_valid = 1'b1;
      if_pc    = {r_inflight_pc, 2'b00};
      if_inst  = rom_data;
    end
`endif
  end

  // A forwarded word that is consumed the same cycle never enters the FIFO.
  assign w_pop      = if_valid && !stall && !flush;
  assign w_pop_fifo = w_pop && !w_bypass;
  assign w_push     = r_inflight && !flush && !(w_bypass && w_pop);

  // Occupancy after this cycle's pop and in-flight landing; a new read is
  // only issued if it is guaranteed a free slot when its data returns.
  assign w_level  = {1'b0, r_count} - {{c_CW{1'b0}}, w_pop} + {{c_CW{1'b0}}, r_inflight};
  assign w_issue  = rst && !flush && (w_level < c_DEPTH);

  assign rom_ce   = w_issue;
  assign rom_addr = {r_fetch_pc, 2'b00};

  // Fetch PC and the single in-flight read tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC[31:2];
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (flush) begin
      r_fetch_pc    <= new_pc[31:2];
      r_inflight    <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 30'd1;
      end
    end
  end

  // FIFO pointers and occupancy; flush empties the buffer outright.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)     r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_fifo) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{(c_CW-1){1'b0}}, w_push} - {{(c_CW-1){1'b0}}, w_pop_fifo};
    end
  end

  // FIFO storage: returning ROM word together with its PC tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_inst[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_mem_inst[r_wr_ptr] <= rom_data;
      r_mem_pc[r_wr_ptr]   <= r_inflight_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch_buf.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_if_prefetch_buf
//  Purpose  : Self-checking bench for if_prefetch_buf: directed vector table,
//             hand-written corner sequences and a randomized run against a
//             stream-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_prefetch_buf;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef PREFETCH_BYPASS_EN
  localparam bit          BYPASS   = 1'b1;
`else
  localparam bit          BYPASS   = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  if_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .flush(flush), .new_pc(new_pc), .stall(stall),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: word at byte address A holds A/4; data is junk unless a read was issued.
  always @(posedge clk) rom_data <= rom_ce ? (rom_addr >> 2) : $urandom();

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the fetch stream and the delivered stream are each just
  // a sequential PC restarted by redirects; the buffer holds "outstanding"
  // words (issued, not yet consumed), of which "inflight" were issued last cycle.
  int          m_out;
  int          m_infl;
  logic [31:0] m_fetch;
  logic [31:0] m_head;
  bit          m_valid;
  bit          m_pop;
  bit          m_ce;

  always @(negedge clk) begin
    if (!rst) begin
      m_out   = 0;
      m_infl  = 0;
      m_fetch = RESET_PC;
      m_head  = RESET_PC;
      chk("m_rst_ce",    {31'b0, rom_ce},   32'd0);
      chk("m_rst_addr",  rom_addr,          RESET_PC);
      chk("m_rst_valid", {31'b0, if_valid}, 32'd0);
      chk("m_rst_pc",    if_pc,             32'd0);
      chk("m_rst_inst",  if_inst,           32'd0);
    end else begin
      m_valid = BYPASS ? (m_out > 0) : ((m_out - m_infl) > 0);
      m_pop   = m_valid && !stall && !flush;
      m_ce    = !flush && ((m_out - int'(m_pop)) < DEPTH);
      chk("m_valid", {31'b0, if_valid}, {31'b0, m_valid});
      chk("m_pc",    if_pc,   m_valid ? m_head : 32'd0);
      chk("m_inst",  if_inst, m_valid ? (m_head >> 2) : 32'd0);
      chk("m_ce",    {31'b0, rom_ce}, {31'b0, m_ce});
      chk("m_addr",  rom_addr, m_fetch);
      if (flush) begin
        m_out   = 0;
        m_infl  = 0;
        m_fetch = {new_pc[31:2], 2'b00};
        m_head  = {new_pc[31:2], 2'b00};
      end else begin
        m_out  = m_out - int'(m_pop) + int'(m_ce);
        m_infl = int'(m_ce);
        if (m_ce)  m_fetch = m_fetch + 32'd4;
        if (m_pop) m_head  = m_head + 32'd4;
      end
    end
  end

  typedef struct packed {
    logic        flush;
    logic        stall;
    logic [31:0] new_pc;
    logic        ce;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } tv_t;

  function automatic tv_t mk(input logic f, input logic s, input logic [31:0] np,
                             input logic ce, input logic [31:0] a,
                             input logic v, input logic [31:0] pc, input logic [31:0] inst);
    tv_t t;
    t.flush = f;  t.stall = s; t.new_pc = np;
    t.ce = ce;    t.addr = a;  t.valid = v; t.pc = pc; t.inst = inst;
    return t;
  endfunction

  tv_t tv [15];

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; stall = 1'b0; new_pc = 32'h0;

    // Reset-release stream, stall fill to DEPTH, release, flush+stall redirect.
`ifdef PREFETCH_BYPASS_EN
    tv[0]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h00,  32'h0);
    tv[1]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b1, 32'h00,  32'h0);
    tv[2]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h04,  32'h1);
    tv[3]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h08,  32'h2);
    tv[4]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h0C,  32'h3);
    tv[5]  = mk(1'b0, 1'b1, 32'h0,   1'b1, 32'h014, 1'b1, 32'h10,  32'h4);
    tv[6]  = mk(1'b0, 1'b1, 32'h0,   1'b1, 32'h018, 1'b1, 32'h10,  32'h4);
    tv[7]  = mk(1'b0, 1'b1, 32'h0,   1'b1, 32'h01C, 1'b1, 32'h10,  32'h4);
    tv[8]  = mk(1'b0, 1'b1, 32'h0,   1'b0, 32'h020, 1'b1, 32'h10,  32'h4);
    tv[9]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h020, 1'b1, 32'h10,  32'h4);
    tv[10] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h024, 1'b1, 32'h14,  32'h5);
    tv[11] = mk(1'b1, 1'b1, 32'h103, 1'b0, 32'h028, 1'b1, 32'h18,  32'h6);
    tv[12] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h00,  32'h0);
    tv[13] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b1, 32'h100, 32'h40);
    tv[14] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h104, 32'h41);
`else
    tv[0]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h000, 1'b0, 32'h00,  32'h0);
    tv[1]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h004, 1'b0, 32'h00,  32'h0);
    tv[2]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h008, 1'b1, 32'h00,  32'h0);
    tv[3]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h00C, 1'b1, 32'h04,  32'h1);
    tv[4]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h010, 1'b1, 32'h08,  32'h2);
    tv[5]  = mk(1'b0, 1'b1, 32'h0,   1'b1, 32'h014, 1'b1, 32'h0C,  32'h3);
    tv[6]  = mk(1'b0, 1'b1, 32'h0,   1'b1, 32'h018, 1'b1, 32'h0C,  32'h3);
    tv[7]  = mk(1'b0, 1'b1, 32'h0,   1'b0, 32'h01C, 1'b1, 32'h0C,  32'h3);
    tv[8]  = mk(1'b0, 1'b1, 32'h0,   1'b0, 32'h01C, 1'b1, 32'h0C,  32'h3);
    tv[9]  = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h01C, 1'b1, 32'h0C,  32'h3);
    tv[10] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h020, 1'b1, 32'h10,  32'h4);
    tv[11] = mk(1'b1, 1'b1, 32'h103, 1'b0, 32'h024, 1'b1, 32'h14,  32'h5);
    tv[12] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h00,  32'h0);
    tv[13] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h00,  32'h0);
    tv[14] = mk(1'b0, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100, 32'h40);
`endif

    repeat (3) next_cycle();
    chk("rst_hold_ce",    {31'b0, rom_ce},   32'd0);
    chk("rst_hold_addr",  rom_addr,          RESET_PC);
    chk("rst_hold_valid", {31'b0, if_valid}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      flush  = tv[i].flush;
      stall  = tv[i].stall;
      new_pc = tv[i].new_pc;
      @(negedge clk);
      chk($sformatf("tv%0d_ce", i),    {31'b0, rom_ce},   {31'b0, tv[i].ce});
      chk($sformatf("tv%0d_addr", i),  rom_addr,          tv[i].addr);
      chk($sformatf("tv%0d_valid", i), {31'b0, if_valid}, {31'b0, tv[i].valid});
      chk($sformatf("tv%0d_pc", i),    if_pc,             tv[i].pc);
      chk($sformatf("tv%0d_inst", i),  if_inst,           tv[i].inst);
      next_cycle();
    end
    flush = 1'b0; stall = 1'b0;

    // Back-to-back flushes: only the last target is fetched.
    flush = 1'b1; new_pc = 32'h0000_0200; next_cycle();
    new_pc = 32'h0000_0300; next_cycle();
    flush = 1'b0;
    @(negedge clk);
    chk("dflush_addr",  rom_addr,          32'h0000_0300);
    chk("dflush_ce",    {31'b0, rom_ce},   32'd1);
    chk("dflush_valid", {31'b0, if_valid}, 32'd0);
    next_cycle();

    // Fetch PC wraps from the top of the address space; low target bits dropped.
    flush = 1'b1; new_pc = 32'hFFFF_FFFE; next_cycle();
    flush = 1'b0;
    @(negedge clk);
    chk("wrap_addr0", rom_addr, 32'hFFFF_FFFC);
    next_cycle();
    @(negedge clk);
    chk("wrap_addr1", rom_addr, 32'h0000_0000);
    next_cycle();
    repeat (4) next_cycle();

    // Asynchronous reset between clock edges.
    chk("pre_arst_valid", {31'b0, if_valid}, 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'b0, if_valid}, 32'd0);
    chk("arst_ce",    {31'b0, rom_ce},   32'd0);
    chk("arst_addr",  rom_addr,          RESET_PC);
    chk("arst_pc",    if_pc,             32'd0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("restart_ce",   {31'b0, rom_ce}, 32'd1);
    chk("restart_addr", rom_addr,        RESET_PC);
    next_cycle();

    // Randomized traffic, checked by the reference model.
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 99) < 35);
      flush = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 7) == 0)
        new_pc = 32'hFFFF_FFF0 | {28'h0, 4'($urandom_range(0, 15))};
      else
        new_pc = $urandom();
      next_cycle();
    end
    flush = 1'b0; stall = 1'b0;
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
